input_port_router: RTL and testbench

Receive side of one router link: accepts packets from a neighbouring router (or the local cache response path) into a small FIFO, decodes the destination network address with dimension-ordered XY routing, and presents the head packet to exactly one of the four output port arbiters or to the local cache arbiter. It is the upstream feeder of the output arbiters' per-direction `selectBit_*` inputs; one instance sits behind each of the N/S/E/W link inputs.

---
 rtl/router_pkg.sv | 33 +++
 rtl/sync_fifo.sv | 50 +++++
 rtl/input_port_router.sv | 126 ++++++++++++
 tb/tb_input_port_router.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: direction indices, default address widths and
// the dimension-ordered (X then Y) routing decision.
package router_pkg;

  localparam int DIR_N     = 0;
  localparam int DIR_S     = 1;
  localparam int DIR_E     = 2;
  localparam int DIR_W     = 3;
  localparam int DIR_LOCAL = 4;

  localparam int NUM_PORTS              = 4;
  localparam int DEFAULT_NA_WIDTH       = 4;
  localparam int DEFAULT_CBA_WIDTH      = 8;
  localparam int DROP_COUNT_WIDTH       = 8;

  typedef logic [2:0] dir_t;

  // X is resolved completely before Y; a packet already at its column and row
  // belongs to the local cache.
  function automatic dir_t route_xy(input int unsigned dest_x,
                                    input int unsigned dest_y,
                                    input int unsigned local_x,
                                    input int unsigned local_y);
    dir_t result;
    if (dest_x > local_x)      result = dir_t'(DIR_E);
    else if (dest_x < local_x) result = dir_t'(DIR_W);
    else if (dest_y > local_y) result = dir_t'(DIR_N);
    else if (dest_y < local_y) result = dir_t'(DIR_S);
    else                       result = dir_t'(DIR_LOCAL);
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers. The head entry is read straight
// from the storage array so it is visible the cycle after it is written.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;
  assign head_data = r_mem[r_rd_ptr[AW-1:0]];

  // Storage array: written only on an accepted push, never cleared.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Pointer update; reset flushes the queue by equalising the pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/input_port_router.sv
// Receive side of one router link: buffers incoming packets, XY-routes the
// head packet and requests exactly one output arbiter or the local cache.
module input_port_router
  import router_pkg::*;
#(
  parameter int NETWORK_ADDRESS_WIDTH    = DEFAULT_NA_WIDTH,
  parameter int CACHE_BANK_ADDRESS_WIDTH = DEFAULT_CBA_WIDTH,
  parameter int DATA_WIDTH               = 32,
  parameter int BUFFER_DEPTH             = 4,
  parameter int LOCAL_X                  = 0,
  parameter int LOCAL_Y                  = 0
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic                                                inValid,
  output logic                                                inReady,
  input  logic [NETWORK_ADDRESS_WIDTH+CACHE_BANK_ADDRESS_WIDTH-1:0] destinationAddressIn,
  input  logic [NETWORK_ADDRESS_WIDTH-1:0]                    requesterAddressIn,
  input  logic                                                readIn,
  input  logic                                                writeIn,
  input  logic [DATA_WIDTH-1:0]                               dataIn,
  input  logic [NUM_PORTS-1:0]                                portReady,
  input  logic                                                cacheReady,
  output logic [NUM_PORTS-1:0]                                selectBit,
  output logic                                                cacheSelect,
  output logic [NETWORK_ADDRESS_WIDTH+CACHE_BANK_ADDRESS_WIDTH-1:0] destinationAddressOut,
  output logic [NETWORK_ADDRESS_WIDTH-1:0]                    requesterAddressOut,
  output logic                                                readOut,
  output logic                                                writeOut,
  output logic [DATA_WIDTH-1:0]                               dataOut,
  output logic [DROP_COUNT_WIDTH-1:0]                         dropCount
);

  localparam int NA     = NETWORK_ADDRESS_WIDTH;
  localparam int HALF   = NA / 2;
  localparam int DEST_W = NA + CACHE_BANK_ADDRESS_WIDTH;
  localparam int PKT_W  = DEST_W + NA + 2 + DATA_WIDTH;

  logic [PKT_W-1:0]      w_push_pkt;
  logic [PKT_W-1:0]      w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic [DEST_W-1:0]     w_head_dest;
  logic [NA-1:0]         w_head_req;
  logic                  w_head_rd;
  logic                  w_head_wr;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic [NA-1:0]         w_net;
  logic [HALF-1:0]       w_dest_x;
  logic [HALF-1:0]       w_dest_y;
  dir_t                  w_dir;
  logic                  w_active;
  logic                  w_malformed;
  logic                  w_req;
  logic                  w_target_ready;
  logic [DROP_COUNT_WIDTH-1:0] r_drop_count;

  assign w_push_pkt = {destinationAddressIn, requesterAddressIn, readIn, writeIn, dataIn};
  assign inReady    = !w_full && !reset;
  assign w_push     = inValid && inReady;

  sync_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (BUFFER_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data (w_push_pkt),
    .pop       (w_pop),
    .head_data (w_head),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign {w_head_dest, w_head_req, w_head_rd, w_head_wr, w_head_data} = w_head;

  assign w_net    = w_head_dest[DEST_W-1 -: NA];
  assign w_dest_x = w_net[HALF-1:0];
  assign w_dest_y = w_net[NA-1 -: HALF];
  assign w_dir    = route_xy(32'(w_dest_x), 32'(w_dest_y),
                             32'(LOCAL_X), 32'(LOCAL_Y));

  // Nothing is requested while reset is high, even if stale entries remain.
  assign w_active    = !w_empty && !reset;
  assign w_malformed = (w_head_rd == w_head_wr);
  assign w_req       = w_active && !w_malformed;

  // Ready of whichever target the head is routed to; only used to pop.
  always_comb begin
    w_target_ready = 1'b0;
    if (w_dir == dir_t'(DIR_LOCAL)) w_target_ready = cacheReady;
    else                            w_target_ready = portReady[w_dir[1:0]];
  end

  // Malformed heads leave unconditionally so they cannot block the link.
  assign w_pop = w_active && (w_malformed || w_target_ready);

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_select
      assign selectBit[gi] = w_req && (w_dir == dir_t'(gi));
    end
  endgenerate
  assign cacheSelect = w_req && (w_dir == dir_t'(DIR_LOCAL));

  // Head fields are forced to zero whenever there is no valid head.
  assign destinationAddressOut = w_active ? w_head_dest : '0;
  assign requesterAddressOut   = w_active ? w_head_req  : '0;
  assign readOut               = w_active ? w_head_rd   : 1'b0;
  assign writeOut              = w_active ? w_head_wr   : 1'b0;
  assign dataOut               = w_active ? w_head_data : '0;

  // Saturating count of heads discarded because read and write agree.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_count <= '0;
    end else if (w_active && w_malformed && (r_drop_count != '1)) begin
      r_drop_count <= r_drop_count + 1'b1;
    end
  end

  assign dropCount = r_drop_count;

endmodule

// File: tb/tb_input_port_router.sv
// Self-checking bench for input_port_router at LOCAL=(1,1), DEPTH=4.
// A queue-based reference model predicts head, selects and drop count.
module tb_input_port_router;

  localparam int DEPTH = 4;
  localparam int LX    = 1;
  localparam int LY    = 1;

  typedef struct {
    logic [11:0] dest;
    logic [3:0]  req;
    logic        rd;
    logic        wr;
    logic [31:0] data;
  } pkt_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [11:0] destinationAddressIn;
  logic [3:0]  requesterAddressIn;
  logic        readIn;
  logic        writeIn;
  logic [31:0] dataIn;
  logic [3:0]  portReady;
  logic        cacheReady;
  logic [3:0]  selectBit;
  logic        cacheSelect;
  logic [11:0] destinationAddressOut;
  logic [3:0]  requesterAddressOut;
  logic        readOut;
  logic        writeOut;
  logic [31:0] dataOut;
  logic [7:0]  dropCount;

  int   checks   = 0;
  int   failures = 0;
  pkt_t q[$];
  int   drop_m   = 0;

  input_port_router #(
    .NETWORK_ADDRESS_WIDTH    (4),
    .CACHE_BANK_ADDRESS_WIDTH (8),
    .DATA_WIDTH               (32),
    .BUFFER_DEPTH             (DEPTH),
    .LOCAL_X                  (LX),
    .LOCAL_Y                  (LY)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .inValid               (inValid),
    .inReady               (inReady),
    .destinationAddressIn  (destinationAddressIn),
    .requesterAddressIn    (requesterAddressIn),
    .readIn                (readIn),
    .writeIn               (writeIn),
    .dataIn                (dataIn),
    .portReady             (portReady),
    .cacheReady            (cacheReady),
    .selectBit             (selectBit),
    .cacheSelect           (cacheSelect),
    .destinationAddressOut (destinationAddressOut),
    .requesterAddressOut   (requesterAddressOut),
    .readOut               (readOut),
    .writeOut              (writeOut),
    .dataOut               (dataOut),
    .dropCount             (dropCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected request as {cache, W, E, S, N}: compare X first, then Y.
  function automatic logic [4:0] route5(input logic [11:0] dest);
    int net, hx, hy;
    net = int'(dest[11:8]);
    hx  = net % 4;
    hy  = net / 4;
    if (hx > LX)      return 5'b00100;
    else if (hx < LX) return 5'b01000;
    else if (hy > LY) return 5'b00001;
    else if (hy < LY) return 5'b00010;
    else              return 5'b10000;
  endfunction

  // One clock: check outputs at the falling edge, then advance the model.
  task automatic step();
    logic [4:0] exp_sel;
    logic       do_push;
    pkt_t       p;
    @(negedge clk);
    chk("inReady", 64'(inReady), 64'(!reset && q.size() < DEPTH));
    exp_sel = (reset || q.size() == 0) ? 5'b0 :
              ((q[0].rd == q[0].wr) ? 5'b0 : route5(q[0].dest));
    chk("select", 64'({cacheSelect, selectBit}), 64'(exp_sel));
    chk("dropCount", 64'(dropCount), 64'(drop_m));
    if (!reset && q.size() != 0) begin
      chk("destOut", 64'(destinationAddressOut), 64'(q[0].dest));
      chk("reqOut", 64'(requesterAddressOut), 64'(q[0].req));
      chk("rdwrOut", 64'({readOut, writeOut}), 64'({q[0].rd, q[0].wr}));
      chk("dataOut", 64'(dataOut), 64'(q[0].data));
    end
    @(posedge clk);
    if (reset) begin
      q.delete();
      drop_m = 0;
    end else begin
      do_push = inValid && (q.size() < DEPTH);
      p.dest = destinationAddressIn; p.req = requesterAddressIn;
      p.rd = readIn; p.wr = writeIn; p.data = dataIn;
      if (q.size() != 0) begin
        if (q[0].rd == q[0].wr) begin
          void'(q.pop_front());
          if (drop_m < 255) drop_m++;
        end else if ((route5(q[0].dest) & {cacheReady, portReady}) != 5'b0) begin
          void'(q.pop_front());
        end
      end
      if (do_push) q.push_back(p);
    end
    #1;
  endtask

  task automatic set_pkt(input logic [3:0] net, input logic rd, input logic wr,
                         input logic [31:0] data);
    inValid              = 1'b1;
    destinationAddressIn = {net, 8'($urandom)};
    requesterAddressIn   = 4'($urandom);
    readIn               = rd;
    writeIn              = wr;
    dataIn               = data;
  endtask

  // Push one packet with every target stalled, check the select, then drain.
  task automatic route_check(input string tag, input logic [3:0] net,
                             input logic [4:0] exp_sel);
    portReady = 4'h0; cacheReady = 1'b0;
    set_pkt(net, 1'b1, 1'b0, $urandom);
    step();
    inValid = 1'b0;
    @(negedge clk);
    chk(tag, 64'({cacheSelect, selectBit}), 64'(exp_sel));
    @(posedge clk); #1;
    portReady = 4'hF; cacheReady = 1'b1;
    step();
    step();
    portReady = 4'h0; cacheReady = 1'b0;
  endtask

  initial begin
    reset = 1'b1; inValid = 1'b0; destinationAddressIn = '0; requesterAddressIn = '0;
    readIn = 1'b0; writeIn = 1'b0; dataIn = '0; portReady = 4'h0; cacheReady = 1'b0;

    // Reset state
    step(); step();
    reset = 1'b0;
    step();
    chk("dataOut_after_reset", 64'(dataOut), 64'd0);

    // Local delivery, then empty the cycle after the pop
    cacheReady = 1'b1;
    set_pkt(4'b0101, 1'b1, 1'b0, 32'hCAFE);
    step();
    inValid = 1'b0;
    step();
    step();
    chk("local_empty_after", 64'({cacheSelect, selectBit}), 64'd0);

    // XY ordering
    route_check("xy_west",  4'b1100, 5'b01000);
    route_check("xy_north", 4'b1101, 5'b00001);
    route_check("xy_south", 4'b0001, 5'b00010);
    route_check("xy_east",  4'b0010, 5'b00100);
    route_check("xy_local", 4'b0101, 5'b10000);

    // Backpressure: five pushes to E with E stalled
    portReady = 4'h0; cacheReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_pkt(4'b0110, 1'b1, 1'b0, 32'(100 + i));
      if (i == 4) chk("full_inReady", 64'(inReady), 64'd0);
      step();
    end
    inValid = 1'b0;
    portReady = 4'b0100;
    for (int i = 0; i < 5; i++) step();
    chk("drained_select", 64'({cacheSelect, selectBit}), 64'd0);

    // Pointer wrap: ten back-to-back packets with the target always ready
    portReady = 4'hF; cacheReady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_pkt(4'b0110, 1'b0, 1'b1, 32'(i));
      step();
    end
    inValid = 1'b0;
    step(); step();

    // Malformed followed by a valid read
    set_pkt(4'b0110, 1'b1, 1'b1, 32'hBAD);
    step();
    set_pkt(4'b0110, 1'b1, 1'b0, 32'h600D);
    step();
    inValid = 1'b0;
    step(); step();
    chk("drop_one", 64'(dropCount), 64'd1);

    // Saturation
    for (int i = 0; i < 300; i++) begin
      set_pkt(4'($urandom), 1'(i % 2), 1'(i % 2), 32'(i));
      step();
    end
    inValid = 1'b0;
    step(); step();
    chk("drop_saturated", 64'(dropCount), 64'd255);

    // Reset mid-stream with three queued entries
    portReady = 4'h0; cacheReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_pkt(4'b1110, 1'b1, 1'b0, 32'(200 + i));
      step();
    end
    inValid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("reset_flush_select", 64'({cacheSelect, selectBit}), 64'd0);
    chk("reset_flush_drop", 64'(dropCount), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic r;
      r = 1'($urandom);
      set_pkt(4'($urandom), r, ($urandom_range(0, 7) == 0) ? r : !r, $urandom);
      inValid    = 1'($urandom);
      portReady  = 4'($urandom);
      cacheReady = 1'($urandom);
      if (i == 300) reset = 1'b1;
      step();
      reset = 1'b0;
    end
    inValid = 1'b0; portReady = 4'hF; cacheReady = 1'b1;
    for (int i = 0; i < 6; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
